// File: rtl/abs_diff_err_sweeper_if.sv
// abs_diff_err_sweeper_if: control, DUT-operand and error-statistics bundle of the sweeper
interface abs_diff_err_sweeper_if #(parameter int W = 2, parameter int OW = 2);
   localparam int EW = (W > OW) ? W : OW;
   logic start;
   logic abort;
   logic busy;
   logic done;
   logic aborted;
   logic [W-1:0] dut_a;
   logic [W-1:0] dut_b;
   logic [OW-1:0] dut_y;
   logic [2*W:0] err_cnt;
   logic [EW-1:0] max_err;
   logic [2*W+EW-1:0] sum_err;
   logic first_vld;
   logic [2*W-1:0] first_vec;
   modport master (
      output start, abort, dut_y,
      input busy, done, aborted, dut_a, dut_b, err_cnt, max_err, sum_err, first_vld, first_vec
   );
   modport slave (
      input start, abort, dut_y,
      output busy, done, aborted, dut_a, dut_b, err_cnt, max_err, sum_err, first_vld, first_vec
   );
endinterface

// File: rtl/abs_diff_err_sweeper.sv
// abs_diff_err_sweeper: exhaustive operand sweep and error statistics for an approximate |a-b| netlist
module abs_diff_err_sweeper #(
   parameter int W = 2,
   parameter int OW = 2,
   parameter int DUT_LAT = 0
) (
   input logic clk,
   input logic rst_n,
   abs_diff_err_sweeper_if.slave bus
);
   localparam int EW = (W > OW) ? W : OW;
   localparam int VW = 2 * W;
   localparam int PW = 1 + VW + W;
   localparam logic [VW-1:0] DRAIN_END = VW'(DUT_LAT > 0 ? DUT_LAT - 1 : 0);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} state_t;
   state_t state_q, state_d;
   logic [VW-1:0] v_q, v_d;
   logic aborted_q, aborted_d;
   logic first_vld_q, first_vld_d;
   logic [VW:0] err_cnt_q, err_cnt_d;
   logic [EW-1:0] max_err_q, max_err_d;
   logic [VW+EW-1:0] sum_err_q, sum_err_d;
   logic [VW-1:0] first_vec_q, first_vec_d;
   logic [W-1:0] a, b, exact;
   logic [EW-1:0] exact_e, y_e, err;
   logic [PW-1:0] iss, tail;
   logic issue, flush, tail_vld;
   always_comb begin
      a = v_q[W-1:0];
      b = v_q[VW-1:W];
      issue = state_q == ST_RUN;
      exact = (a >= b) ? a - b : b - a;
      iss = {issue, v_q, exact};
      flush = (state_q == ST_RUN || state_q == ST_DRAIN) && bus.abort;
      tail_vld = tail[PW-1] && !flush;
      exact_e = EW'(tail[W-1:0]);
      y_e = EW'(bus.dut_y);
      err = (exact_e >= y_e) ? exact_e - y_e : y_e - exact_e;
      state_d = state_q;
      v_d = v_q;
      aborted_d = aborted_q;
      first_vld_d = first_vld_q;
      err_cnt_d = err_cnt_q;
      max_err_d = max_err_q;
      sum_err_d = sum_err_q;
      first_vec_d = first_vec_q;
      if (tail_vld && err != '0) begin
         err_cnt_d = err_cnt_q + 1'b1;
         sum_err_d = sum_err_q + (VW+EW)'(err);
         max_err_d = (err > max_err_q) ? err : max_err_q;
         if (!first_vld_q) begin
            first_vld_d = 1'b1;
            first_vec_d = tail[VW+W-1:W];
         end
      end
      case (state_q)
         ST_IDLE: if (bus.start) begin
            state_d = ST_RUN;
            v_d = '0;
            aborted_d = 1'b0;
            first_vld_d = 1'b0;
            err_cnt_d = '0;
            max_err_d = '0;
            sum_err_d = '0;
            first_vec_d = '0;
         end
         ST_RUN: if (bus.abort) begin
            state_d = ST_IDLE;
            aborted_d = 1'b1;
            v_d = '0;
         end else begin
            v_d = v_q + 1'b1;
            if (v_q == '1) state_d = (DUT_LAT > 0) ? ST_DRAIN : ST_FIN;
         end
         ST_DRAIN: if (bus.abort) begin
            state_d = ST_IDLE;
            aborted_d = 1'b1;
            v_d = '0;
         end else begin
            v_d = (v_q == DRAIN_END) ? '0 : v_q + 1'b1;
            state_d = (v_q == DRAIN_END) ? ST_FIN : ST_DRAIN;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   generate
      if (DUT_LAT == 0) begin : g_comb
         assign tail = iss;
      end else begin : g_pipe
         logic [PW-1:0] pipe_q [DUT_LAT];
         logic [PW-1:0] pipe_d [DUT_LAT];
         always_comb begin
            pipe_d[0] = flush ? '0 : iss;
            for (int i = 1; i < DUT_LAT; i++) pipe_d[i] = flush ? '0 : pipe_q[i-1];
         end
         always_ff @(posedge clk) begin
            if (!rst_n) for (int i = 0; i < DUT_LAT; i++) pipe_q[i] <= '0;
            else pipe_q <= pipe_d;
         end
         assign tail = pipe_q[DUT_LAT-1];
      end
   endgenerate
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         v_q <= '0;
         aborted_q <= 1'b0;
         first_vld_q <= 1'b0;
         err_cnt_q <= '0;
         max_err_q <= '0;
         sum_err_q <= '0;
         first_vec_q <= '0;
      end else begin
         state_q <= state_d;
         v_q <= v_d;
         aborted_q <= aborted_d;
         first_vld_q <= first_vld_d;
         err_cnt_q <= err_cnt_d;
         max_err_q <= max_err_d;
         sum_err_q <= sum_err_d;
         first_vec_q <= first_vec_d;
      end
   end
   // operands are forced to zero outside RUN so a pipelined netlist sees quiet inputs
   assign bus.dut_a = issue ? a : '0;
   assign bus.dut_b = issue ? b : '0;
   assign bus.busy = state_q == ST_RUN || state_q == ST_DRAIN;
   assign bus.done = state_q == ST_FIN;
   assign bus.aborted = aborted_q;
   assign bus.err_cnt = err_cnt_q;
   assign bus.max_err = max_err_q;
   assign bus.sum_err = sum_err_q;
   assign bus.first_vld = first_vld_q;
   assign bus.first_vec = first_vec_q;
endmodule

// File: tb/tb_abs_diff_err_sweeper.sv
// tb_abs_diff_err_sweeper: scoreboard bench for combinational and two-cycle-latency sweeper instances
module tb_abs_diff_err_sweeper;
   typedef struct {int cnt; int mx; int sum; int fv; int fvec; int ab; int len;} exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int mode = 0;
   int n_chk = 0;
   int n_pass = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   logic bz[2], dn[2], ab[2], fv[2];
   logic [4:0] ec[2];
   logic [1:0] mx[2], da[2], db[2];
   logic [5:0] sm[2];
   logic [3:0] fvec[2];
   logic pbz[2] = '{1'b0, 1'b0};
   logic was_done[2] = '{1'b0, 1'b0};
   int blen[2] = '{0, 0};
   logic [1:0] d1 = '0, d2 = '0;
   abs_diff_err_sweeper_if #(.W(2), .OW(2)) if0 ();
   abs_diff_err_sweeper_if #(.W(2), .OW(2)) if1 ();
   abs_diff_err_sweeper #(.W(2), .OW(2), .DUT_LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   abs_diff_err_sweeper #(.W(2), .OW(2), .DUT_LAT(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   always #5 clk = ~clk;
   function automatic logic [1:0] absd(logic [1:0] a, logic [1:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction
   function automatic exp_t mk(int cnt, int mx_v, int sum, int fv_v, int fvec_v, int ab_v, int len);
      exp_t e;
      e.cnt = cnt; e.mx = mx_v; e.sum = sum; e.fv = fv_v; e.fvec = fvec_v; e.ab = ab_v; e.len = len;
      return e;
   endfunction
   assign if0.dut_y = (mode == 0) ? absd(if0.dut_a, if0.dut_b) : (mode == 1) ? 2'd0 : 2'd3;
   assign if1.dut_y = (mode == 0) ? d2 : (mode == 1) ? 2'd0 : 2'd3;
   always @(posedge clk) begin
      d1 <= absd(if1.dut_a, if1.dut_b);
      d2 <= d1;
   end
   always_comb begin
      bz[0] = if0.busy; dn[0] = if0.done; ab[0] = if0.aborted; fv[0] = if0.first_vld;
      ec[0] = if0.err_cnt; mx[0] = if0.max_err; sm[0] = if0.sum_err; fvec[0] = if0.first_vec;
      da[0] = if0.dut_a; db[0] = if0.dut_b;
      bz[1] = if1.busy; dn[1] = if1.done; ab[1] = if1.aborted; fv[1] = if1.first_vld;
      ec[1] = if1.err_cnt; mx[1] = if1.max_err; sm[1] = if1.sum_err; fvec[1] = if1.first_vec;
      da[1] = if1.dut_a; db[1] = if1.dut_b;
   end
   task automatic chk(string name, int act, int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
   endtask
   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_idle();
      int k = 0;
      while ((bz[0] || bz[1] || dn[0] || dn[1]) && k < 100) begin
         cyc(1);
         k++;
      end
      chk("sweep_timeout", k < 100, 1);
      cyc(2);
   endtask
   // monitor: issue order, drain quietness, done width, and stats at every sweep end
   always @(negedge clk) begin
      for (int j = 0; j < 2; j++) begin
         exp_t e;
         if (was_done[j]) chk($sformatf("done_width%0d", j), int'(dn[j]), 0);
         was_done[j] = dn[j];
         if (bz[j]) begin
            blen[j]++;
            if (blen[j] <= 16) begin
               chk($sformatf("order_a%0d", j), int'(da[j]), (blen[j] - 1) % 4);
               chk($sformatf("order_b%0d", j), int'(db[j]), (blen[j] - 1) / 4);
            end else begin
               chk($sformatf("drain_a%0d", j), int'(da[j]), 0);
               chk($sformatf("drain_b%0d", j), int'(db[j]), 0);
            end
         end
         if (dn[j] || (pbz[j] && !bz[j])) begin
            if ((j == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
               n_chk++;
               $display("FAIL unexpected_end%0d: got sweep end, expected none", j);
            end else begin
               e = (j == 0) ? sb0.pop_front() : sb1.pop_front();
               chk($sformatf("err_cnt%0d", j), int'(ec[j]), e.cnt);
               chk($sformatf("max_err%0d", j), int'(mx[j]), e.mx);
               chk($sformatf("sum_err%0d", j), int'(sm[j]), e.sum);
               chk($sformatf("first_vld%0d", j), int'(fv[j]), e.fv);
               chk($sformatf("first_vec%0d", j), int'(fvec[j]), e.fvec);
               chk($sformatf("aborted%0d", j), int'(ab[j]), e.ab);
               chk($sformatf("done_flag%0d", j), int'(dn[j]), (e.ab == 0 && e.len >= 16) ? 1 : 0);
               chk($sformatf("busy_len%0d", j), blen[j], e.len);
            end
            blen[j] = 0;
         end
         pbz[j] = bz[j];
      end
   end
   initial begin
      if0.start = 1'b0; if0.abort = 1'b0;
      if1.start = 1'b0; if1.abort = 1'b0;
      cyc(2);
      if0.start = 1'b1; if1.start = 1'b1;
      cyc(1);
      if0.start = 1'b0; if1.start = 1'b0;
      for (int j = 0; j < 2; j++) begin
         chk($sformatf("rst_busy%0d", j), int'(bz[j]), 0);
         chk($sformatf("rst_done%0d", j), int'(dn[j]), 0);
         chk($sformatf("rst_aborted%0d", j), int'(ab[j]), 0);
         chk($sformatf("rst_stats%0d", j), int'(ec[j]) + int'(mx[j]) + int'(sm[j]), 0);
         chk($sformatf("rst_first%0d", j), int'(fv[j]) + int'(fvec[j]), 0);
         chk($sformatf("rst_ops%0d", j), int'(da[j]) + int'(db[j]), 0);
      end
      rst_n = 1'b1;
      cyc(1);
      mode = 0;
      sb0.push_back(mk(0, 0, 0, 0, 0, 0, 16));
      sb1.push_back(mk(0, 0, 0, 0, 0, 0, 18));
      if0.start = 1'b1; if1.start = 1'b1;
      cyc(1);
      if0.start = 1'b0; if1.start = 1'b0;
      wait_idle();
      mode = 1;
      sb0.push_back(mk(12, 3, 20, 1, 1, 0, 16));
      sb1.push_back(mk(12, 3, 20, 1, 1, 0, 18));
      if0.start = 1'b1; if1.start = 1'b1;
      cyc(1);
      if0.start = 1'b0; if1.start = 1'b0;
      wait_idle();
      mode = 2;
      sb0.push_back(mk(14, 3, 28, 1, 0, 0, 16));
      sb1.push_back(mk(14, 3, 28, 1, 0, 0, 18));
      if0.start = 1'b1; if1.start = 1'b1;
      cyc(1);
      if0.start = 1'b0; if1.start = 1'b0;
      cyc(7);
      if0.start = 1'b1; if1.start = 1'b1;
      cyc(1);
      if0.start = 1'b0; if1.start = 1'b0;
      wait_idle();
      mode = 1;
      sb0.push_back(mk(4, 3, 7, 1, 1, 1, 6));
      if0.start = 1'b1; if0.abort = 1'b1;
      cyc(1);
      if0.start = 1'b0; if0.abort = 1'b0;
      cyc(5);
      if0.abort = 1'b1;
      cyc(1);
      if0.abort = 1'b0;
      wait_idle();
      chk("aborted_held", int'(ab[0]), 1);
      mode = 0;
      sb0.push_back(mk(0, 0, 0, 0, 0, 0, 16));
      if0.start = 1'b1;
      cyc(1);
      if0.start = 1'b0;
      wait_idle();
      mode = 1;
      sb0.push_back(mk(0, 0, 0, 0, 0, 0, 7));
      if0.start = 1'b1;
      cyc(1);
      if0.start = 1'b0;
      cyc(6);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      wait_idle();
      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
